game_fsm: RTL and testbench

- Top-level match controller for the Pong design.
- Debounces the start button and produces the 2-bit game_state that gates ball motion.
- Watches p1_score/p2_score coming back from the ball block to insert a post-point pause and detect the winner.
- Issues a one-cycle game_reset pulse; the top level ORs it into the ball block's reset to clear position and scores for a new match.

---
 rtl/game_fsm.sv | 140 ++++++++++++++
 tb/tb_game_fsm.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/game_fsm.sv
// game_fsm: Pong match controller. It debounces the start button, runs the
// IDLE/PLAY/PAUSE/OVER state machine, inserts a timed pause after each point,
// detects the winner, and pulses game_reset when a finished match is restarted.
// Ports:
//   clk, reset (async, active-high), tick_1ms (1-cycle ms strobe),
//   btn_start (raw button), p1_score/p2_score (from ball block),
//   game_state (00 IDLE, 01 PLAY, 10 PAUSE, 11 OVER),
//   winner (00 none, 01 p1, 10 p2), game_reset (1-cycle clear request).
// Latency: an accepted press or a score change moves game_state one clk later.
module game_fsm #(
  parameter int DEBOUNCE_MS    = 20,
  parameter int POINT_PAUSE_MS = 1000,
  parameter int WIN_SCORE      = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1ms,
  input  logic       btn_start,
  input  logic [3:0] p1_score,
  input  logic [3:0] p2_score,
  output logic [1:0] game_state,
  output logic [1:0] winner,
  output logic       game_reset
);

  // Counter widths; each counter tops out at its parameter minus one.
  localparam int DB_W = (DEBOUNCE_MS > 1) ? $clog2(DEBOUNCE_MS) : 1;
  localparam int PT_W = (POINT_PAUSE_MS > 1) ? $clog2(POINT_PAUSE_MS) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_MS - 1);
  localparam logic [PT_W-1:0] PT_LAST = PT_W'(POINT_PAUSE_MS - 1);
  localparam logic [3:0]      WIN     = 4'(WIN_SCORE);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PLAY  = 2'b01,
    PAUSE = 2'b10,
    OVER  = 2'b11
  } state_t;

  state_t          state;
  logic            sync_0;
  logic            sync_1;
  logic            stable;
  logic            stable_d;
  logic [DB_W-1:0] db_cnt;
  logic [PT_W-1:0] timer;
  logic [3:0]      p1_prev;
  logic [3:0]      p2_prev;
  logic            press;
  logic            score_evt;

  // Button synchroniser and debouncer. The counter only runs while the
  // synchronised level disagrees with the accepted level, so any bounce back
  // to the accepted level restarts the qualification window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_0   <= 1'b0;
      sync_1   <= 1'b0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      db_cnt   <= '0;
    end else begin
      sync_0   <= btn_start;
      sync_1   <= sync_0;
      stable_d <= stable;
      if (sync_1 == stable) begin
        db_cnt <= '0;
      end else if (tick_1ms) begin
        if (db_cnt == DB_LAST) begin
          stable <= sync_1;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end
      end
    end
  end

  // One pulse per accepted press; releases are ignored.
  assign press = stable & ~stable_d;

  // Any change of either score since the previous cycle marks a point.
  assign score_evt = (p1_score != p1_prev) | (p2_score != p2_prev);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      winner     <= 2'b00;
      game_reset <= 1'b0;
      timer      <= '0;
      p1_prev    <= 4'd0;
      p2_prev    <= 4'd0;
    end else begin
      p1_prev    <= p1_score;
      p2_prev    <= p2_score;
      game_reset <= 1'b0;
      case (state)
        IDLE: begin
          if (press) state <= PLAY;
        end
        PLAY: begin
          // Player 1 wins a simultaneous reach of the winning score.
          if (score_evt) begin
            if (p1_score >= WIN) begin
              state  <= OVER;
              winner <= 2'b01;
            end else if (p2_score >= WIN) begin
              state  <= OVER;
              winner <= 2'b10;
            end else begin
              state <= PAUSE;
              timer <= '0;
            end
          end
        end
        PAUSE: begin
          if (tick_1ms) begin
            if (timer == PT_LAST) begin
              state <= PLAY;
              timer <= '0;
            end else begin
              timer <= timer + PT_W'(1);
            end
          end
        end
        OVER: begin
          if (press) begin
            state      <= IDLE;
            winner     <= 2'b00;
            game_reset <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign game_state = state;

endmodule

// File: tb/tb_game_fsm.sv
// tb_game_fsm: directed bench for game_fsm with default parameters
// (DEBOUNCE_MS=20, POINT_PAUSE_MS=1000, WIN_SCORE=9). tick_1ms is one clk
// in every four. Inputs change 1 time unit after the rising edge and outputs
// are sampled at the same point.
module tb_game_fsm;

  logic       clk;
  logic       reset;
  logic       tick_1ms;
  logic       btn_start;
  logic [3:0] p1_score;
  logic [3:0] p2_score;
  logic [1:0] game_state;
  logic [1:0] winner;
  logic       game_reset;

  int checks;
  int failures;

  game_fsm dut (
    .clk        (clk),
    .reset      (reset),
    .tick_1ms   (tick_1ms),
    .btn_start  (btn_start),
    .p1_score   (p1_score),
    .p2_score   (p2_score),
    .game_state (game_state),
    .winner     (winner),
    .game_reset (game_reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock with tick_1ms set to t; returns 1 time unit after the edge.
  task automatic cyc(input logic t);
    tick_1ms = t;
    @(posedge clk);
    #1;
    tick_1ms = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1);
      cyc(1'b0);
      cyc(1'b0);
      cyc(1'b0);
    end
  endtask

  // Hold the button until it is accepted; returns on the cycle where the
  // state machine has acted on the press.
  task automatic press_btn();
    btn_start = 1'b1;
    repeat (4) cyc(1'b0);
    ticks(19);
    cyc(1'b1);
    cyc(1'b0);
  endtask

  task automatic release_btn();
    btn_start = 1'b0;
    ticks(25);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    tick_1ms  = 1'b0;
    btn_start = 1'b0;
    p1_score  = 4'd0;
    p2_score  = 4'd0;
    cyc(1'b0);
    check("rst_state", game_state, 2'b00);
    check("rst_winner", winner, 2'b00);
    check("rst_greset", game_reset, 1'b0);
    reset = 1'b0;
    cyc(1'b0);

    // Score changes in IDLE are ignored.
    p1_score = 4'd8;
    p2_score = 4'd3;
    repeat (3) cyc(1'b0);
    check("idle_score_ignored", game_state, 2'b00);

    // Chatter: toggle every 3 ticks for 30 ticks, never qualifies.
    for (int k = 0; k < 10; k++) begin
      btn_start = ~btn_start;
      ticks(3);
    end
    btn_start = 1'b0;
    ticks(3);
    check("chatter_idle", game_state, 2'b00);

    // Clean press: accepted on the 20th tick, PLAY one clk after the press.
    btn_start = 1'b1;
    repeat (4) cyc(1'b0);
    ticks(19);
    check("db_19_ticks", game_state, 2'b00);
    cyc(1'b1);
    check("db_20th_tick", game_state, 2'b00);
    cyc(1'b0);
    check("db_press_play", game_state, 2'b01);
    ticks(5);
    release_btn();
    check("release_no_change", game_state, 2'b01);

    // Point by player 2: 3 -> 4 gives PAUSE for exactly 1000 ticks.
    p2_score = 4'd4;
    cyc(1'b0);
    check("point_pause", game_state, 2'b10);
    btn_start = 1'b1;
    ticks(25);
    check("pause_press_ignored", game_state, 2'b10);
    btn_start = 1'b0;
    ticks(25);
    ticks(949);
    check("pause_999_ticks", game_state, 2'b10);
    cyc(1'b1);
    check("pause_done", game_state, 2'b01);

    // Player 1 reaches 9 -> OVER, winner 01.
    p1_score = 4'd9;
    cyc(1'b0);
    check("p1_win_state", game_state, 2'b11);
    check("p1_win_winner", winner, 2'b01);
    press_btn();
    check("restart_state", game_state, 2'b00);
    check("restart_winner", winner, 2'b00);
    check("restart_greset", game_reset, 1'b1);
    p1_score = 4'd0;
    p2_score = 4'd0;
    cyc(1'b0);
    check("greset_one_clk", game_reset, 1'b0);
    release_btn();
    check("cleared_scores_idle", game_state, 2'b00);

    // Both players reach 9 together: player 1 wins.
    p1_score = 4'd8;
    p2_score = 4'd8;
    cyc(1'b0);
    press_btn();
    check("tie_play", game_state, 2'b01);
    release_btn();
    p1_score = 4'd9;
    p2_score = 4'd9;
    cyc(1'b0);
    check("tie_state", game_state, 2'b11);
    check("tie_winner", winner, 2'b01);
    press_btn();
    release_btn();
    p1_score = 4'd0;
    p2_score = 4'd0;
    cyc(1'b0);

    // Reset mid-pause (timer at 500).
    press_btn();
    release_btn();
    p1_score = 4'd1;
    cyc(1'b0);
    check("rp_pause", game_state, 2'b10);
    ticks(500);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_state", game_state, 2'b00);
    check("async_rst_greset", game_reset, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc(1'b0);
    check("post_rst_greset", game_reset, 1'b0);
    check("post_rst_idle", game_state, 2'b00);
    press_btn();
    check("post_rst_play", game_state, 2'b01);
    release_btn();
    p2_score = 4'd1;
    cyc(1'b0);
    check("post_rst_pause", game_state, 2'b10);
    ticks(999);
    check("full_pause_999", game_state, 2'b10);
    cyc(1'b1);
    check("full_pause_done", game_state, 2'b01);

    // Player 2 reaches 9 -> winner 10.
    p2_score = 4'd9;
    cyc(1'b0);
    check("p2_win_state", game_state, 2'b11);
    check("p2_win_winner", winner, 2'b10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
